// File: rtl/zcache_mem_arbiter_pkg.sv
// Shared types and constants for the zcache/icache memory-port arbiter.
// Bus commands, tag/size widths, owner-table entry and arbiter debug view.
package zcache_mem_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int MEM_SIZE_W = 2;
  localparam int MEM_TAG_W  = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_ZC     = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } owner_entry_t;

  typedef struct packed {
    logic locked;
    logic lock_owner;
    logic rr_ptr;
    logic winner;
    logic grant;
  } arb_dbg_t;

endpackage

// File: rtl/zcache_mem_arbiter_mem_tag_owner_table.sv
// Remembers which requester owns each outstanding load tag.
// One allocate port and one lookup/clear port; allocate wins a same-tag collision.
module mem_tag_owner_table
  import zcache_mem_arbiter_pkg::*;
#(
  parameter int TAG_W    = MEM_TAG_W,
  parameter int NUM_TAGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             alloc_owner,
  input  logic [TAG_W-1:0] lookup_tag,
  output owner_entry_t     lookup_entry
);

  owner_entry_t entries [NUM_TAGS];

  assign lookup_entry = entries[lookup_tag];

  // Clear is written first so an allocate of the same tag overrides it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAGS; i++) entries[i] <= '0;
    end else begin
      if (lookup_tag != '0 && entries[lookup_tag].valid) entries[lookup_tag] <= '0;
      if (alloc_en) entries[alloc_tag] <= '{valid: 1'b1, owner: alloc_owner};
    end
  end

endmodule

// File: rtl/zcache_mem_arbiter.sv
// Shares one processor memory port between icache (0) and zcache (1),
// and routes returning load tags back to the requester that issued them.
module zcache_mem_arbiter
  import zcache_mem_arbiter_pkg::*;
#(
  parameter int TAG_W        = MEM_TAG_W,
  parameter int NUM_TAGS     = 16,
  parameter int FIXED_PRIO   = 0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            icache_command,
  input  logic [XLEN-1:0]       icache_addr,
  input  logic [63:0]           icache_data,
  input  logic [MEM_SIZE_W-1:0] icache_size,
  input  logic [1:0]            zc_command,
  input  logic [XLEN-1:0]       zc_addr,
  input  logic [63:0]           zc_data,
  input  logic [MEM_SIZE_W-1:0] zc_size,
  input  logic [TAG_W-1:0]      mem2proc_response,
  input  logic [TAG_W-1:0]      mem2proc_tag,
  input  logic [63:0]           mem2proc_data,
  output logic [1:0]            proc2mem_command,
  output logic [XLEN-1:0]       proc2mem_addr,
  output logic [63:0]           proc2mem_data,
  output logic [MEM_SIZE_W-1:0] proc2mem_size,
  output logic [TAG_W-1:0]      icache_response,
  output logic [TAG_W-1:0]      zc_response,
  output logic [TAG_W-1:0]      icache_tag,
  output logic [TAG_W-1:0]      zc_tag,
  output logic [63:0]           icache_rdata,
  output logic [63:0]           zc_rdata,
  output logic                  err_orphan_tag,
  output arb_dbg_t              dbg_state
);

  // Handshake: proc2mem_command != BUS_NONE is the request valid; a nonzero
  // mem2proc_response in that same cycle is acceptance, otherwise the grant is held.
  localparam logic [0:0] ST_OPEN   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [0:0]       lock_state;
  logic             lock_owner;
  logic             rr_ptr;
  logic [CNT_W-1:0] starve_ic;
  logic [CNT_W-1:0] starve_zc;
  logic             err_q;

  logic ic_act, zc_act, ic_starved, zc_starved, lock_owner_act;
  logic winner, grant_valid, grant, accepted, alloc_en, ret_hit;
  owner_entry_t ret_entry;

  assign ic_act         = icache_command != BUS_NONE;
  assign zc_act         = zc_command != BUS_NONE;
  assign ic_starved     = ic_act && (starve_ic == LIMIT);
  assign zc_starved     = zc_act && (starve_zc == LIMIT);
  assign lock_owner_act = (lock_owner == REQ_ZC) ? zc_act : ic_act;

  always_comb begin
    winner = REQ_ICACHE;
    if (lock_state == ST_LOCKED && lock_owner_act) winner = lock_owner;
    else if (ic_starved && !zc_starved)            winner = REQ_ICACHE;
    else if (zc_starved && !ic_starved)            winner = REQ_ZC;
    else if (ic_act && !zc_act)                    winner = REQ_ICACHE;
    else if (zc_act && !ic_act)                    winner = REQ_ZC;
    else if (FIXED_PRIO != 0)                      winner = REQ_ZC;
    else                                           winner = rr_ptr;
  end

  // While reset is low everything presents idle, independent of the clock.
  assign grant_valid = (winner == REQ_ZC) ? zc_act : ic_act;
  assign grant       = reset && grant_valid;
  assign accepted    = grant && (mem2proc_response != '0);

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = '0;
    icache_response  = '0;
    zc_response      = '0;
    if (grant) begin
      if (winner == REQ_ZC) begin
        proc2mem_command = zc_command;
        proc2mem_addr    = zc_addr;
        proc2mem_data    = zc_data;
        proc2mem_size    = zc_size;
        zc_response      = mem2proc_response;
      end else begin
        proc2mem_command = icache_command;
        proc2mem_addr    = icache_addr;
        proc2mem_data    = icache_data;
        proc2mem_size    = icache_size;
        icache_response  = mem2proc_response;
      end
    end
  end

  assign alloc_en = accepted && (proc2mem_command == BUS_LOAD);

  mem_tag_owner_table #(
    .TAG_W    (TAG_W),
    .NUM_TAGS (NUM_TAGS)
  ) u_owner_table (
    .clk          (clk),
    .reset        (reset),
    .alloc_en     (alloc_en),
    .alloc_tag    (mem2proc_response),
    .alloc_owner  (winner),
    .lookup_tag   (mem2proc_tag),
    .lookup_entry (ret_entry)
  );

  assign ret_hit        = reset && (mem2proc_tag != '0) && ret_entry.valid;
  assign icache_tag     = (ret_hit && ret_entry.owner == REQ_ICACHE) ? mem2proc_tag : '0;
  assign zc_tag         = (ret_hit && ret_entry.owner == REQ_ZC) ? mem2proc_tag : '0;
  assign icache_rdata   = reset ? mem2proc_data : '0;
  assign zc_rdata       = reset ? mem2proc_data : '0;
  assign err_orphan_tag = err_q;

  assign dbg_state = '{locked: lock_state[0], lock_owner: lock_owner, rr_ptr: rr_ptr,
                       winner: winner, grant: grant};

  function automatic logic [CNT_W-1:0] next_starve(input logic [CNT_W-1:0] cnt,
                                                   input logic act, input logic won,
                                                   input logic acc);
    if (won && acc) return '0;
    if (act && !won && cnt != LIMIT) return cnt + 1'b1;
    return cnt;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_state <= ST_OPEN;
      lock_owner <= REQ_ICACHE;
      rr_ptr     <= REQ_ICACHE;
      starve_ic  <= '0;
      starve_zc  <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_state <= (grant && mem2proc_response == '0) ? ST_LOCKED : ST_OPEN;
      if (grant) lock_owner <= winner;
      if (accepted && ic_act && zc_act) rr_ptr <= ~winner;
      starve_ic <= next_starve(starve_ic, ic_act, winner == REQ_ICACHE, accepted);
      starve_zc <= next_starve(starve_zc, zc_act, winner == REQ_ZC, accepted);
      if (mem2proc_tag != '0 && !ret_entry.valid) err_q <= 1'b1;
    end
  end

endmodule
